// File: rtl/xy_duty_sequencer.sv
// xy_duty_sequencer: X/Y duty-word generator tracing outline, fill, centre or diagonal shapes,
// updating only on PWM period boundaries and publishing the shared PWM counter.
module xy_duty_sequencer #(
    parameter int PWM_BITS         = 6,
    parameter int PERIODS_PER_STEP = 3,
    parameter int STEPS_PER_EDGE   = 16
) (
    input  logic                sysclk,
    input  logic                reset,
    input  logic                enable,
    input  logic [1:0]          shape_sel,
    output logic [PWM_BITS-1:0] pwm_count,
    output logic                period_tick,
    output logic [PWM_BITS-1:0] duty_x,
    output logic [PWM_BITS-1:0] duty_y,
    output logic                frame_tick,
    output logic [1:0]          active_shape
);
    localparam int W = PWM_BITS;
    localparam int PW = PERIODS_PER_STEP > 1 ? $clog2(PERIODS_PER_STEP) : 1;
    localparam int SW = STEPS_PER_EDGE > 1 ? $clog2(STEPS_PER_EDGE) : 1;
    localparam int SH = $clog2((2 ** W) / STEPS_PER_EDGE);
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] HALF = W'(2 ** (W - 1));

    logic [PW-1:0] per, per_n;
    logic [SW-1:0] s, s_n, r, r_n;
    logic [1:0]    e, e_n, sh;
    logic          run, per_wrap, s_wrap, last, advance;
    logic [W-1:0]  rs, rr, dx_n, dy_n;

    // run records whether enable was high at the start of the current period,
    // so a partial period after enable rises is never counted.
    always_comb begin
        period_tick = pwm_count == MAX;
        per_wrap = per == PW'(PERIODS_PER_STEP - 1);
        s_wrap = per_wrap && s == SW'(STEPS_PER_EDGE - 1);
        last = s_wrap && (active_shape == 2'd0 ? e == 2'd3 :
                          active_shape == 2'd1 ? r == SW'(STEPS_PER_EDGE - 1) : 1'b1);
        advance = period_tick && enable && run;
        frame_tick = advance && last;
        per_n = advance && !per_wrap ? per + PW'(1) : '0;
        s_n = advance && !s_wrap ? (per_wrap ? s + SW'(1) : s) : '0;
        e_n = !advance ? '0 : (s_wrap && active_shape == 2'd0) ? e + 2'd1 : e;
        r_n = !advance || (s_wrap && r == SW'(STEPS_PER_EDGE - 1)) ? '0 :
              (s_wrap && active_shape == 2'd1) ? r + SW'(1) : r;
        sh = advance && !last ? active_shape : shape_sel;
        rs = W'(s_n) << SH;
        rr = W'(r_n) << SH;
        dx_n = sh == 2'd0 ? (e_n == 2'd0 ? rs : e_n == 2'd1 ? MAX : e_n == 2'd2 ? MAX - rs : '0) :
               sh == 2'd1 ? rs : sh == 2'd2 ? HALF : rs;
        dy_n = sh == 2'd0 ? (e_n == 2'd0 ? '0 : e_n == 2'd1 ? rs : e_n == 2'd2 ? MAX : MAX - rs) :
               sh == 2'd1 ? rr : sh == 2'd2 ? HALF : rs;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            pwm_count <= '0;
            per <= '0;
            s <= '0;
            e <= '0;
            r <= '0;
            duty_x <= '0;
            duty_y <= '0;
            run <= enable;
            active_shape <= shape_sel;
        end else begin
            pwm_count <= pwm_count + W'(1);
            if (period_tick) begin
                per <= per_n;
                s <= s_n;
                e <= e_n;
                r <= r_n;
                run <= enable;
                active_shape <= sh;
                duty_x <= enable ? dx_n : '0;
                duty_y <= enable ? dy_n : '0;
            end
        end
    end
endmodule

// File: tb/tb_xy_duty_sequencer.sv
// tb_xy_duty_sequencer: frame-level reference model checked every cycle, plus literal pins
// at hand-computed cycles for reset, edges, shape switch, fill rows, enable gaps and mid-frame reset.
module tb_xy_duty_sequencer;
    logic       sysclk = 0, reset = 1, enable = 1;
    logic [1:0] shape_sel = 0;
    logic [5:0] pwm_count, duty_x, duty_y;
    logic       period_tick, frame_tick;
    logic [1:0] active_shape;

    int  errors = 0, checks = 0, cyc = 0;
    bit  mon = 0;
    int  m_cnt = 0, m_per = 0, m_shape = 0, m_dx = 0, m_dy = 0;
    bit  m_run = 0;

    xy_duty_sequencer dut (
        .sysclk(sysclk), .reset(reset), .enable(enable), .shape_sel(shape_sel),
        .pwm_count(pwm_count), .period_tick(period_tick), .duty_x(duty_x), .duty_y(duty_y),
        .frame_tick(frame_tick), .active_shape(active_shape)
    );

    always #5 sysclk = ~sysclk;

    // Frame length in PWM periods: 3 periods/step times the steps in one frame of each shape.
    function automatic int flen(input int sh);
        return sh == 0 ? 3 * 64 : sh == 1 ? 3 * 256 : 3 * 16;
    endfunction

    function automatic void fduty(input int sh, input int step, output int dx, output int dy);
        int k;
        k = (step % 16) * 4;
        if (sh == 0) begin
            case (step / 16)
                0: begin dx = k; dy = 0; end
                1: begin dx = 63; dy = k; end
                2: begin dx = 63 - k; dy = 63; end
                default: begin dx = 0; dy = 63 - k; end
            endcase
        end else if (sh == 1) begin
            dx = k; dy = (step / 16) * 4;
        end else if (sh == 2) begin
            dx = 32; dy = 32;
        end else begin
            dx = k; dy = k;
        end
    endfunction

    always @(posedge sysclk) begin
        int c, p, sh, dx, dy;
        bit rn;
        c = m_cnt; p = m_per; sh = m_shape; dx = m_dx; dy = m_dy; rn = m_run;
        if (reset) begin
            c = 0; p = 0; sh = shape_sel; dx = 0; dy = 0; rn = enable;
        end else begin
            if (c == 63) begin
                if (!enable) begin
                    p = 0; rn = 0; sh = shape_sel; dx = 0; dy = 0;
                end else begin
                    if (rn) begin
                        p = p + 1;
                        if (p == flen(sh)) begin p = 0; sh = shape_sel; end
                    end else begin
                        rn = 1; p = 0; sh = shape_sel;
                    end
                    fduty(sh, p / 3, dx, dy);
                end
            end
            c = (c + 1) % 64;
        end
        m_cnt <= c; m_per <= p; m_shape <= sh; m_dx <= dx; m_dy <= dy; m_run <= rn;
        cyc <= reset ? 0 : cyc + 1;
        mon <= 1;
    end

    always @(negedge sysclk) begin
        bit ept, eft;
        if (mon) begin
            ept = m_cnt == 63;
            eft = ept && enable && m_run && (m_per + 1 == flen(m_shape));
            checks++;
            if (pwm_count !== 6'(m_cnt) || period_tick !== ept || duty_x !== 6'(m_dx) ||
                duty_y !== 6'(m_dy) || frame_tick !== eft || active_shape !== 2'(m_shape)) begin
                errors++;
                $display("FAIL model cyc=%0d got cnt=%0d pt=%0b dx=%0d dy=%0d ft=%0b sh=%0d want cnt=%0d pt=%0b dx=%0d dy=%0d ft=%0b sh=%0d",
                         cyc, pwm_count, period_tick, duty_x, duty_y, frame_tick, active_shape,
                         m_cnt, ept, m_dx, m_dy, eft, m_shape);
            end
        end
    end

    task automatic at_cyc(input int n);
        while (cyc < n) @(negedge sysclk);
    endtask

    task automatic at_set(input int n);
        at_cyc(n);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, exp);
        end
    endtask

    task automatic duty(input string nm, input int n, input int dx, input int dy);
        at_cyc(n);
        chk({nm, "_x"}, 32'(duty_x), dx);
        chk({nm, "_y"}, 32'(duty_y), dy);
    endtask

    task automatic do_reset(input logic [1:0] sel);
        @(negedge sysclk);
        #2 reset = 1; shape_sel = sel;
        @(posedge sysclk);
        #2 reset = 0;
    endtask

    initial begin
        repeat (2) @(posedge sysclk);
        #2 reset = 0;
        // Outline frame, then switch to centre mid-frame and back.
        at_cyc(0);
        chk("rst_cnt", 32'(pwm_count), 0);
        chk("rst_pt", 32'(period_tick), 0);
        chk("rst_ft", 32'(frame_tick), 0);
        chk("rst_sh", 32'(active_shape), 0);
        duty("rst", 0, 0, 0);
        at_cyc(63);
        chk("tick63", 32'(period_tick), 1);
        chk("cnt63", 32'(pwm_count), 63);
        at_cyc(64);
        chk("wrap_cnt", 32'(pwm_count), 0);
        chk("wrap_pt", 32'(period_tick), 0);
        duty("step0_end", 191, 0, 0);
        duty("step1", 192, 4, 0);
        duty("e0_s15", 3071, 60, 0);
        duty("e1_s0", 3072, 63, 0);
        at_set(5000);
        shape_sel = 2;
        duty("e2_s1", 6336, 59, 63);
        duty("e3_s15", 12096, 0, 3);
        at_cyc(12287);
        chk("ol_ft", 32'(frame_tick), 1);
        chk("ol_sh_hold", 32'(active_shape), 0);
        duty("centre", 12288, 32, 32);
        chk("centre_sh", 32'(active_shape), 2);
        chk("centre_ft", 32'(frame_tick), 0);
        at_set(13000);
        shape_sel = 0;
        at_cyc(15359);
        chk("ctr_ft", 32'(frame_tick), 1);
        duty("ol_restart", 15360, 0, 0);
        chk("ol_restart_sh", 32'(active_shape), 0);
        duty("ol_restart1", 15552, 4, 0);
        // Filled raster.
        do_reset(1);
        duty("fill_s15", 3071, 60, 0);
        duty("fill_r1", 3072, 0, 4);
        chk("fill_sh", 32'(active_shape), 1);
        at_cyc(49150);
        chk("fill_ft_pre", 32'(frame_tick), 0);
        at_cyc(49151);
        chk("fill_ft", 32'(frame_tick), 1);
        duty("fill_last", 49151, 60, 60);
        duty("fill_wrap", 49152, 0, 0);
        // Enable gap with a shape request while disabled.
        do_reset(0);
        at_set(1000);
        enable = 0;
        duty("dis_pre", 1023, 20, 0);
        duty("dis", 1024, 0, 0);
        at_set(1100);
        shape_sel = 3;
        at_cyc(1151);
        chk("dis_sh_pre", 32'(active_shape), 0);
        at_cyc(1152);
        chk("dis_sh", 32'(active_shape), 3);
        at_cyc(1500);
        chk("dis_cnt", 32'(pwm_count), 28);
        chk("dis_ft", 32'(frame_tick), 0);
        at_set(2010);
        enable = 1;
        duty("en_part", 2047, 0, 0);
        duty("en_s0", 2048, 0, 0);
        duty("en_s0_end", 2239, 0, 0);
        duty("en_s1", 2240, 4, 4);
        chk("en_sh", 32'(active_shape), 3);
        // One-cycle reset mid-frame.
        shape_sel = 0;
        do_reset(0);
        at_cyc(0);
        chk("mrst_cnt", 32'(pwm_count), 0);
        chk("mrst_sh", 32'(active_shape), 0);
        chk("mrst_pt", 32'(period_tick), 0);
        duty("mrst", 0, 0, 0);
        duty("mrst_s0", 191, 0, 0);
        duty("mrst_s1", 192, 4, 0);
        duty("mrst_e1", 3072, 63, 0);
        @(negedge sysclk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
